// File: rtl/jtag_reg_pkg.sv
// Shared frame layout, FSM encodings and configuration checks for the
// JTAG USER-chain register controller.
package jtag_reg_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Status bits sit directly above the data field in the response frame.
  localparam int STAT_DONE_OFS    = 0;
  localparam int STAT_TIMEOUT_OFS = 1;
  localparam int STAT_OVERRUN_OFS = 2;

  function automatic int addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int we_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int stat_bit(input int dw, input int ofs);
    return dw + ofs;
  endfunction

  // Command and response frames share one shift register, so both layouts
  // must fill it exactly.
  function automatic bit frame_width_ok(input int aw, input int dw, input int jw,
                                        input int tc);
    return (jw == 1 + aw + dw) && (jw == dw + 3) && (tc >= 1);
  endfunction

endpackage

// File: rtl/jtag_dr_shift.sv
// USER data-register shifter: parallel load at capture, LSB-first shift,
// tdo driven straight from bit 0.
module jtag_dr_shift
  import jtag_reg_pkg::*;
#(
  parameter int JDATA_WIDTH = 35
) (
  input  logic                   tck,
  input  logic                   jtag_resetn,
  input  logic                   sel,
  input  logic                   capture,
  input  logic                   shift,
  input  logic                   tdi,
  input  logic [JDATA_WIDTH-1:0] cap_data,
  output logic [JDATA_WIDTH-1:0] sr,
  output logic                   tdo
);

  always_ff @(posedge tck) begin
    if (!jtag_resetn) begin
      sr <= '0;
    end else if (sel && capture) begin
      sr <= cap_data;
    end else if (sel && shift) begin
      sr <= {tdi, sr[JDATA_WIDTH-1:1]};
    end
  end

  assign tdo = sr[0];

endmodule

// File: rtl/jtag_reg_ctrl.sv
// Turns each JTAG USER frame into one register-bus transaction and reports
// the previous transaction's result and status on the next capture.
module jtag_reg_ctrl
  import jtag_reg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int JDATA_WIDTH    = 35,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  tck,
  input  logic                  jtag_resetn,
  input  logic                  sel,
  input  logic                  capture,
  input  logic                  shift,
  input  logic                  update,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int WE_BIT       = we_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int ADDR_LSB     = addr_lsb(DATA_WIDTH);
  localparam int STAT_DONE    = stat_bit(DATA_WIDTH, STAT_DONE_OFS);
  localparam int STAT_TIMEOUT = stat_bit(DATA_WIDTH, STAT_TIMEOUT_OFS);
  localparam int STAT_OVERRUN = stat_bit(DATA_WIDTH, STAT_OVERRUN_OFS);
  localparam int CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (!frame_width_ok(ADDR_WIDTH, DATA_WIDTH, JDATA_WIDTH, TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("jtag_reg_ctrl: inconsistent frame widths or TIMEOUT_CYCLES");
  end

  logic [0:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   done;
  logic                   timeout_f;
  logic                   overrun;
  logic [JDATA_WIDTH-1:0] sr;
  logic [JDATA_WIDTH-1:0] cap_data;
  logic                   cmd_capture;
  logic                   cmd_update;

  assign cmd_capture = capture & sel;
  assign cmd_update  = update & sel;

  always_comb begin
    cap_data                   = '0;
    cap_data[DATA_WIDTH-1:0]   = rdata_q;
    cap_data[STAT_DONE]        = done;
    cap_data[STAT_TIMEOUT]     = timeout_f;
    cap_data[STAT_OVERRUN]     = overrun;
  end

  jtag_dr_shift #(
    .JDATA_WIDTH(JDATA_WIDTH)
  ) u_dr_shift (
    .tck        (tck),
    .jtag_resetn(jtag_resetn),
    .sel        (sel),
    .capture    (capture),
    .shift      (shift),
    .tdi        (tdi),
    .cap_data   (cap_data),
    .sr         (sr),
    .tdo        (tdo)
  );

  // Capture clears the flags first; any set from the FSM below on the same
  // edge is written later and therefore wins.
  always_ff @(posedge tck) begin
    if (!jtag_resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      done      <= 1'b0;
      timeout_f <= 1'b0;
      overrun   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      if (cmd_capture) begin
        done      <= 1'b0;
        timeout_f <= 1'b0;
        overrun   <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_update) begin
            bus_we    <= sr[WE_BIT];
            bus_addr  <= sr[ADDR_LSB +: ADDR_WIDTH];
            bus_wdata <= sr[DATA_WIDTH-1:0];
            bus_req   <= 1'b1;
            cnt       <= '0;
            done      <= 1'b0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cmd_update) begin
            overrun <= 1'b1;
          end
          if (bus_ack) begin
            if (!bus_we) begin
              rdata_q <= bus_rdata;
            end
            done    <= 1'b1;
            bus_req <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout_f <= 1'b1;
            done      <= 1'b0;
            bus_req   <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_reg_ctrl.sv
// Directed bench for jtag_reg_ctrl: write, read, timeout, overrun, sel gating
// and mid-transaction reset, with hand-computed expected frames.
module tb_jtag_reg_ctrl;

  logic        tck = 1'b0;
  logic        jtag_resetn;
  logic        sel, capture, shift, update, tdi;
  logic        tdo;
  logic        bus_req, bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [34:0] frame;
  logic [34:0] pat;
  int          high;

  always #5 tck = ~tck;

  jtag_reg_ctrl dut (
    .tck        (tck),
    .jtag_resetn(jtag_resetn),
    .sel        (sel),
    .capture    (capture),
    .shift      (shift),
    .update     (update),
    .tdi        (tdi),
    .tdo        (tdo),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] make_cmd(input logic we, input logic [1:0] addr,
                                           input logic [31:0] data);
    return {we, addr, data};
  endfunction

  task automatic shift_in(input logic [34:0] f);
    sel = 1'b1;
    shift = 1'b1;
    for (int i = 0; i < 35; i++) begin
      tdi = f[i];
      step();
    end
    shift = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic shift_out(output logic [34:0] f);
    sel = 1'b1;
    tdi = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < 35; i++) begin
      f[i] = tdo;
      step();
    end
    shift = 1'b0;
  endtask

  task automatic capture_read(output logic [34:0] f);
    sel = 1'b1;
    capture = 1'b1;
    step();
    capture = 1'b0;
    shift_out(f);
  endtask

  task automatic update_pulse();
    sel = 1'b1;
    update = 1'b1;
    step();
    update = 1'b0;
  endtask

  // Counts cycles with bus_req high; acks (with rd) on the ack_after-th
  // high cycle, never when ack_after is 0. Bounded at 300 cycles.
  task automatic run_bus(input int ack_after, input logic [31:0] rd, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!bus_req) break;
      n++;
      if (n == ack_after) begin
        bus_ack = 1'b1;
        bus_rdata = rd;
      end
      step();
      bus_ack = 1'b0;
    end
  endtask

  initial begin
    jtag_resetn = 1'b0;
    sel = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    step(); step(); step();
    check("rst_tdo", tdo, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    jtag_resetn = 1'b1;
    step();
    capture_read(frame);
    check("rst_frame", frame, 35'h0_0000_0000);

    // Write, acked on the third request cycle.
    shift_in(make_cmd(1'b1, 2'd2, 32'hDEADBEEF));
    update_pulse();
    check("wr_req", bus_req, 1);
    check("wr_we", bus_we, 1);
    check("wr_addr", bus_addr, 2);
    check("wr_wdata", bus_wdata, 32'hDEADBEEF);
    run_bus(3, 32'h5555_5555, high);
    check("wr_req_cycles", high, 3);
    capture_read(frame);
    check("wr_status", frame, 35'h1_0000_0000);

    // Read, acked in the first BUSY cycle.
    shift_in(make_cmd(1'b0, 2'd1, 32'h0));
    update_pulse();
    check("rd_we", bus_we, 0);
    check("rd_addr", bus_addr, 1);
    run_bus(1, 32'h12345678, high);
    check("rd_req_cycles", high, 1);
    capture_read(frame);
    check("rd_frame", frame, 35'h1_1234_5678);
    capture_read(frame);
    check("rd_frame_clr", frame, 35'h0_1234_5678);

    // Timeout with no ack.
    shift_in(make_cmd(1'b0, 2'd3, 32'h0));
    update_pulse();
    run_bus(0, 32'h0, high);
    check("to_req_cycles", high, 255);
    capture_read(frame);
    check("to_frame", frame, 35'h2_1234_5678);
    capture_read(frame);
    check("to_frame_clr", frame, 35'h0_1234_5678);

    // Overrun: second update while busy is dropped.
    shift_in(make_cmd(1'b1, 2'd3, 32'hA5A5A5A5));
    update_pulse();
    shift_in(make_cmd(1'b1, 2'd0, 32'h1111_2222));
    update_pulse();
    check("ov_req", bus_req, 1);
    check("ov_addr", bus_addr, 3);
    check("ov_wdata", bus_wdata, 32'hA5A5A5A5);
    run_bus(1, 32'hFFFF_0000, high);
    check("ov_req_cycles", high, 1);
    capture_read(frame);
    check("ov_frame", frame, 35'h5_1234_5678);

    // sel=0 gating, plus a spurious ack while idle.
    pat = make_cmd(1'b1, 2'd1, 32'h0F0F0F0F);
    shift_in(pat);
    sel = 1'b0;
    capture = 1'b1; shift = 1'b1; update = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      tdi = i[0];
      step();
    end
    capture = 1'b0; shift = 1'b0; update = 1'b0; bus_ack = 1'b0; tdi = 1'b0;
    check("gate_tdo", tdo, 1);
    check("gate_req", bus_req, 0);
    shift_out(frame);
    check("gate_sr", frame, pat);
    capture_read(frame);
    check("gate_frame", frame, 35'h0_1234_5678);

    // Reset in the middle of a busy transaction with overrun pending.
    shift_in(make_cmd(1'b1, 2'd2, 32'h0000_0003));
    update_pulse();
    step();
    update_pulse();
    check("mr_req_pre", bus_req, 1);
    check("mr_tdo_pre", tdo, 1);
    jtag_resetn = 1'b0;
    step();
    check("mr_req", bus_req, 0);
    check("mr_tdo", tdo, 0);
    check("mr_we", bus_we, 0);
    check("mr_addr", bus_addr, 0);
    check("mr_wdata", bus_wdata, 0);
    jtag_resetn = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    step();
    bus_ack = 1'b0;
    check("mr_late_ack_req", bus_req, 0);
    capture_read(frame);
    check("mr_frame", frame, 35'h0_0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
